// File: rtl/uart_cmd_pkg.sv
// -----------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command parser and its register bank.
//   HDR_DEFAULT  default frame start marker
//   CMD_*        recognised command identifiers
//   state_e      parser FSM encoding (visible on debug_state)
//   mode_e       converter mode encoding
//   is_known_cmd helper used to split good frames into applied / unknown
// -----------------------------------------------------------------------------
package uart_cmd_pkg;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  localparam logic [7:0] CMD_VSET = 8'h01;
  localparam logic [7:0] CMD_ILIM = 8'h02;
  localparam logic [7:0] CMD_CTRL = 8'h03;
  localparam logic [7:0] CMD_OFF  = 8'h04;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GOT_HDR = 3'd1,
    ST_GOT_CMD = 3'd2,
    ST_GOT_DH  = 3'd3,
    ST_GOT_DL  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_AUTO  = 2'b00,
    MODE_BUCK  = 2'b01,
    MODE_BOOST = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_VSET) || (cmd == CMD_ILIM) ||
           (cmd == CMD_CTRL) || (cmd == CMD_OFF);
  endfunction

endpackage

// File: rtl/uart_cmd_regs.sv
// -----------------------------------------------------------------------------
// uart_cmd_regs
// Converter control register bank, written by a decoded command.
//   clk_27m_i  system clock
//   rst_n_i    synchronous active-low reset
//   wr_en_i    write strobe (one cycle, checksum already verified)
//   cmd_i      command identifier selecting the target register
//   data_i     16-bit payload {DH,DL}
//   vset_o     voltage setpoint
//   ilim_o     current limit
//   pwr_en_o   converter enable
//   mode_o     converter mode (reserved value stored as written)
// -----------------------------------------------------------------------------
module uart_cmd_regs
  import uart_cmd_pkg::*;
#(
  parameter logic [15:0] VSET_RST = 16'd0,
  parameter logic [15:0] ILIM_RST = 16'd0
) (
  input  logic        clk_27m_i,
  input  logic        rst_n_i,
  input  logic        wr_en_i,
  input  logic [7:0]  cmd_i,
  input  logic [15:0] data_i,
  output logic [15:0] vset_o,
  output logic [15:0] ilim_o,
  output logic        pwr_en_o,
  output logic [1:0]  mode_o
);

  logic [15:0] vset_q, vset_d;
  logic [15:0] ilim_q, ilim_d;
  logic        pwr_en_q, pwr_en_d;
  mode_e       mode_q, mode_d;

  always_comb begin
    vset_d   = vset_q;
    ilim_d   = ilim_q;
    pwr_en_d = pwr_en_q;
    mode_d   = mode_q;
    if (wr_en_i) begin
      case (cmd_i)
        CMD_VSET: vset_d = data_i;
        CMD_ILIM: ilim_d = data_i;
        CMD_CTRL: begin
          pwr_en_d = data_i[0];
          mode_d   = mode_e'(data_i[2:1]);
        end
        // Emergency off: payload is deliberately ignored.
        CMD_OFF:  pwr_en_d = 1'b0;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk_27m_i) begin
    if (!rst_n_i) begin
      vset_q   <= VSET_RST;
      ilim_q   <= ILIM_RST;
      pwr_en_q <= 1'b0;
      mode_q   <= MODE_AUTO;
    end else begin
      vset_q   <= vset_d;
      ilim_q   <= ilim_d;
      pwr_en_q <= pwr_en_d;
      mode_q   <= mode_d;
    end
  end

  assign vset_o   = vset_q;
  assign ilim_o   = ilim_q;
  assign pwr_en_o = pwr_en_q;
  assign mode_o   = mode_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
// Frames the UART byte stream into 5-byte packets HDR,CMD,DH,DL,CHK with
// CHK = (CMD+DH+DL) mod 256, and applies good packets to the control
// registers of the buck-boost converter.
//   clk_27m      system clock
//   rst_n        synchronous active-low reset
//   rx_data      received byte, stable while rx_valid is high
//   rx_valid     level, new byte on rising edge
//   rx_error     level, framing error on rising edge
//   vset, ilim   setpoint / current-limit registers
//   pwr_en, mode converter enable and mode
//   cmd_valid    pulse: good frame applied
//   cmd_id       command byte of the last good frame
//   chk_err      pulse: checksum mismatch
//   cmd_err      pulse: checksum OK, unknown command
//   tmo_err      pulse: inter-byte timeout or rx_error abort
//   frame_cnt    good-frame counter (wraps)
//   debug_state  current FSM state
// -----------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = HDR_DEFAULT,
  parameter int          TIMEOUT_CYC = 60000,
  parameter int          TMO_W       = 17,
  parameter logic [15:0] VSET_RST    = 16'd0,
  parameter logic [15:0] ILIM_RST    = 16'd0
) (
  input  logic        clk_27m,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [15:0] vset,
  output logic [15:0] ilim,
  output logic        pwr_en,
  output logic [1:0]  mode,
  output logic        cmd_valid,
  output logic [7:0]  cmd_id,
  output logic        chk_err,
  output logic        cmd_err,
  output logic        tmo_err,
  output logic [7:0]  frame_cnt,
  output logic [2:0]  debug_state
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             rx_valid_q, rx_error_q;
  logic             byte_stb, err_stb, tmo_hit;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       dh_q, dh_d;
  logic [7:0]       dl_q, dl_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             chk_err_q, chk_err_d;
  logic             cmd_err_q, cmd_err_d;
  logic             tmo_err_q, tmo_err_d;
  logic [7:0]       cmd_id_q, cmd_id_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             reg_we;

  assign byte_stb = rx_valid & ~rx_valid_q;
  assign err_stb  = rx_error & ~rx_error_q;
  assign tmo_hit  = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_LAST);

  // Inter-byte timer: only runs while a frame is open; saturates at the
  // terminal value so a stuck state can never wrap back to a small count.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE || byte_stb) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q != TMO_LAST) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    dh_d        = dh_q;
    dl_d        = dl_q;
    sum_d       = sum_q;
    cmd_valid_d = 1'b0;
    chk_err_d   = 1'b0;
    cmd_err_d   = 1'b0;
    tmo_err_d   = 1'b0;
    cmd_id_d    = cmd_id_q;
    frame_cnt_d = frame_cnt_q;
    reg_we      = 1'b0;

    // Priority: receive error aborts an open frame and swallows any byte
    // arriving in the same cycle; a byte beats a coincident timeout.
    if (err_stb && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      tmo_err_d = 1'b1;
    end else if (byte_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == HDR_BYTE) state_d = ST_GOT_HDR;
        end
        ST_GOT_HDR: begin
          cmd_d   = rx_data;
          sum_d   = rx_data;
          state_d = ST_GOT_CMD;
        end
        ST_GOT_CMD: begin
          dh_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = ST_GOT_DH;
        end
        ST_GOT_DH: begin
          dl_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = ST_GOT_DL;
        end
        ST_GOT_DL: begin
          state_d = ST_IDLE;
          if (rx_data != sum_q) begin
            chk_err_d = 1'b1;
          end else if (is_known_cmd(cmd_q)) begin
            reg_we      = 1'b1;
            cmd_valid_d = 1'b1;
            cmd_id_d    = cmd_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d   = ST_IDLE;
      tmo_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_27m) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rx_valid_q  <= 1'b0;
      rx_error_q  <= 1'b0;
      cmd_q       <= 8'd0;
      dh_q        <= 8'd0;
      dl_q        <= 8'd0;
      sum_q       <= 8'd0;
      tmo_cnt_q   <= '0;
      cmd_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
      tmo_err_q   <= 1'b0;
      cmd_id_q    <= 8'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid;
      rx_error_q  <= rx_error;
      cmd_q       <= cmd_d;
      dh_q        <= dh_d;
      dl_q        <= dl_d;
      sum_q       <= sum_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cmd_valid_q <= cmd_valid_d;
      chk_err_q   <= chk_err_d;
      cmd_err_q   <= cmd_err_d;
      tmo_err_q   <= tmo_err_d;
      cmd_id_q    <= cmd_id_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // The write uses the latched DH/DL; the checksum byte itself is not data.
  uart_cmd_regs #(
    .VSET_RST (VSET_RST),
    .ILIM_RST (ILIM_RST)
  ) u_regs (
    .clk_27m_i (clk_27m),
    .rst_n_i   (rst_n),
    .wr_en_i   (reg_we),
    .cmd_i     (cmd_q),
    .data_i    ({dh_q, dl_q}),
    .vset_o    (vset),
    .ilim_o    (ilim),
    .pwr_en_o  (pwr_en),
    .mode_o    (mode)
  );

  assign cmd_valid   = cmd_valid_q;
  assign chk_err     = chk_err_q;
  assign cmd_err     = cmd_err_q;
  assign tmo_err     = tmo_err_q;
  assign cmd_id      = cmd_id_q;
  assign frame_cnt   = frame_cnt_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
module tb_uart_cmd_parser;
  // Short timeout keeps the run small; all timing is expressed relative to it.
  localparam int T_CYC = 300;

  logic        clk_27m = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_error = 1'b0;
  logic [15:0] vset, ilim;
  logic        pwr_en, cmd_valid, chk_err, cmd_err, tmo_err;
  logic [1:0]  mode;
  logic [7:0]  cmd_id, frame_cnt;
  logic [2:0]  debug_state;

  uart_cmd_parser #(.TIMEOUT_CYC(T_CYC)) dut (
    .clk_27m(clk_27m), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .vset(vset), .ilim(ilim), .pwr_en(pwr_en), .mode(mode),
    .cmd_valid(cmd_valid), .cmd_id(cmd_id), .chk_err(chk_err), .cmd_err(cmd_err),
    .tmo_err(tmo_err), .frame_cnt(frame_cnt), .debug_state(debug_state)
  );

  always #5 clk_27m = ~clk_27m;

  int checks = 0;
  int failures = 0;

  // Edge counter and pulse monitor (pulses sampled on the edge after they rise).
  int cyc = 0;
  int mon_valid = 0, mon_chk = 0, mon_cmd = 0, mon_tmo = 0, mon_multi = 0;
  always @(posedge clk_27m) begin
    cyc <= cyc + 1;
    if (cmd_valid) mon_valid <= mon_valid + 1;
    if (chk_err)   mon_chk   <= mon_chk + 1;
    if (cmd_err)   mon_cmd   <= mon_cmd + 1;
    if (tmo_err)   mon_tmo   <= mon_tmo + 1;
    if ((int'(cmd_valid) + int'(chk_err) + int'(cmd_err) + int'(tmo_err)) > 1)
      mon_multi <= mon_multi + 1;
  end

  // ---------------- reference model (frame-level) ----------------
  logic [7:0]  frame[$];
  logic [15:0] m_vset, m_ilim;
  logic        m_en;
  logic [1:0]  m_mode;
  logic [7:0]  m_id, m_cnt;
  int          e_valid = 0, e_chk = 0, e_cmd = 0, e_tmo = 0;
  int          last_strobe = 0;

  function automatic void model_reset();
    frame.delete();
    m_vset = 16'd0; m_ilim = 16'd0; m_en = 1'b0; m_mode = 2'b00;
    m_id = 8'd0; m_cnt = 8'd0;
  endfunction

  // An open frame is abandoned once T_CYC edges pass after its last byte.
  function automatic void model_timeout(input int lim);
    if (frame.size() != 0 && last_strobe + T_CYC <= lim) begin
      e_tmo++;
      frame.delete();
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int s;
    if (frame.size() == 0) begin
      if (b == 8'hA5) frame.push_back(b);
    end else begin
      frame.push_back(b);
      if (frame.size() == 5) begin
        s = (int'(frame[1]) + int'(frame[2]) + int'(frame[3])) % 256;
        if (int'(frame[4]) != s) e_chk++;
        else if (frame[1] >= 8'd1 && frame[1] <= 8'd4) begin
          if (frame[1] == 8'd1) m_vset = {frame[2], frame[3]};
          if (frame[1] == 8'd2) m_ilim = {frame[2], frame[3]};
          if (frame[1] == 8'd3) begin m_en = frame[3][0]; m_mode = frame[3][2:1]; end
          if (frame[1] == 8'd4) m_en = 1'b0;
          m_id = frame[1];
          m_cnt = m_cnt + 8'd1;
          e_valid++;
        end else e_cmd++;
        frame.delete();
      end
    end
  endfunction

  // ---------------- stimulus (all tasks start and end on a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input int hold, input int idle);
    model_timeout(cyc);          // strobe edge will be cyc+1
    model_byte(b);
    last_strobe = cyc + 1;
    rx_data = b; rx_valid = 1'b1;
    repeat (hold) @(negedge clk_27m);
    rx_valid = 1'b0;
    repeat (idle) @(negedge clk_27m);
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4, input int hold, input int idle);
    send_byte(b0, hold, idle); send_byte(b1, hold, idle); send_byte(b2, hold, idle);
    send_byte(b3, hold, idle); send_byte(b4, hold, idle);
  endtask

  task automatic send_error(input logic with_byte, input logic [7:0] b, input int idle);
    model_timeout(cyc);
    if (frame.size() != 0) begin
      e_tmo++;
      frame.delete();
    end else if (with_byte) begin
      model_byte(b);
      last_strobe = cyc + 1;
    end
    rx_error = 1'b1;
    if (with_byte) begin rx_data = b; rx_valid = 1'b1; end
    @(negedge clk_27m);
    rx_error = 1'b0; rx_valid = 1'b0;
    repeat (idle) @(negedge clk_27m);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk_27m);
    model_timeout(cyc - 1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_27m);
    checks++; if (vset !== 16'd0) begin failures++; $display("FAIL reset_vset got=%h exp=0000", vset); end
    checks++; if (ilim !== 16'd0) begin failures++; $display("FAIL reset_ilim got=%h exp=0000", ilim); end
    checks++; if (pwr_en !== 1'b0 || mode !== 2'b00) begin failures++; $display("FAIL reset_ctrl got=%b/%b exp=0/00", pwr_en, mode); end
    checks++; if ({cmd_valid, chk_err, cmd_err, tmo_err} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%b exp=0000", {cmd_valid, chk_err, cmd_err, tmo_err}); end
    checks++; if (cmd_id !== 8'd0 || frame_cnt !== 8'd0) begin failures++; $display("FAIL reset_id_cnt got=%h/%h exp=00/00", cmd_id, frame_cnt); end
    checks++; if (debug_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", debug_state); end
    rst_n = 1'b1;
    @(negedge clk_27m);
  endtask

  task automatic test_vset_frame();
    send_frame(8'hA5, 8'h01, 8'h0B, 8'hB8, 8'hC4, 1, T_CYC / 2 - 1);
    settle(2);
    checks++; if (vset !== m_vset) begin failures++; $display("FAIL vset_frame got=%h exp=%h", vset, m_vset); end
    checks++; if (cmd_id !== m_id || frame_cnt !== m_cnt) begin failures++; $display("FAIL vset_id_cnt got=%h/%h exp=%h/%h", cmd_id, frame_cnt, m_id, m_cnt); end
    checks++; if (mon_valid !== e_valid || mon_chk + mon_cmd + mon_tmo !== e_chk + e_cmd + e_tmo) begin failures++; $display("FAIL vset_pulses got=%0d/%0d exp=%0d/%0d", mon_valid, mon_chk + mon_cmd + mon_tmo, e_valid, e_chk + e_cmd + e_tmo); end
  endtask

  task automatic test_ctrl_off();
    send_frame(8'hA5, 8'h03, 8'h00, 8'h03, 8'h06, 2, 5);
    settle(2);
    checks++; if (pwr_en !== m_en || mode !== m_mode) begin failures++; $display("FAIL ctrl_write got=%b/%b exp=%b/%b", pwr_en, mode, m_en, m_mode); end
    send_frame(8'hA5, 8'h04, 8'h00, 8'h00, 8'h04, 1, 3);
    settle(2);
    checks++; if (pwr_en !== m_en || mode !== m_mode) begin failures++; $display("FAIL off_write got=%b/%b exp=%b/%b", pwr_en, mode, m_en, m_mode); end
    checks++; if (frame_cnt !== m_cnt || cmd_id !== m_id) begin failures++; $display("FAIL off_cnt got=%h/%h exp=%h/%h", frame_cnt, cmd_id, m_cnt, m_id); end
  endtask

  task automatic test_bad_checksum();
    send_frame(8'hA5, 8'h02, 8'h01, 8'hF4, 8'h00, 1, 4);
    settle(2);
    checks++; if (mon_chk !== e_chk) begin failures++; $display("FAIL chk_err_count got=%0d exp=%0d", mon_chk, e_chk); end
    checks++; if (ilim !== m_ilim || frame_cnt !== m_cnt) begin failures++; $display("FAIL chk_no_write got=%h/%h exp=%h/%h", ilim, frame_cnt, m_ilim, m_cnt); end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5, 1, 2); send_byte(8'h01, 1, 2); send_byte(8'h12, 1, 2);
    settle(T_CYC + 5);
    checks++; if (mon_tmo !== e_tmo) begin failures++; $display("FAIL tmo_count got=%0d exp=%0d", mon_tmo, e_tmo); end
    checks++; if (debug_state !== 3'(frame.size())) begin failures++; $display("FAIL tmo_state got=%0d exp=%0d", debug_state, frame.size()); end
    send_frame(8'hA5, 8'h02, 8'h01, 8'hF4, 8'hF7, 1, 3);
    settle(2);
    checks++; if (ilim !== m_ilim) begin failures++; $display("FAIL tmo_then_ilim got=%h exp=%h", ilim, m_ilim); end
    // Gap of exactly T_CYC edges: the byte still makes it.
    send_frame(8'hA5, 8'h01, 8'h12, 8'h34, 8'h47, 1, T_CYC - 1);
    settle(2);
    checks++; if (vset !== m_vset || mon_tmo !== e_tmo) begin failures++; $display("FAIL tmo_edge_ok got=%h/%0d exp=%h/%0d", vset, mon_tmo, m_vset, e_tmo); end
    // One edge longer: the frame is dropped by timeout.
    send_frame(8'hA5, 8'h01, 8'h55, 8'h66, 8'hBC, 1, T_CYC);
    settle(T_CYC + 3);
    checks++; if (vset !== m_vset || mon_tmo !== e_tmo) begin failures++; $display("FAIL tmo_edge_late got=%h/%0d exp=%h/%0d", vset, mon_tmo, m_vset, e_tmo); end
  endtask

  task automatic test_garbage_unknown();
    send_byte(8'h00, 1, 2); send_byte(8'hFF, 1, 2); send_byte(8'h5A, 1, 2);
    send_frame(8'hA5, 8'h09, 8'h00, 8'h00, 8'h09, 1, 2);
    settle(2);
    checks++; if (mon_cmd !== e_cmd || mon_chk !== e_chk || mon_tmo !== e_tmo) begin failures++; $display("FAIL unknown_pulses got=%0d/%0d/%0d exp=%0d/%0d/%0d", mon_cmd, mon_chk, mon_tmo, e_cmd, e_chk, e_tmo); end
    checks++; if (vset !== m_vset || ilim !== m_ilim || frame_cnt !== m_cnt) begin failures++; $display("FAIL unknown_no_write got=%h/%h/%h exp=%h/%h/%h", vset, ilim, frame_cnt, m_vset, m_ilim, m_cnt); end
  endtask

  task automatic test_error_abort();
    send_byte(8'hA5, 6, 2); send_byte(8'h01, 4, 3);
    settle(1);
    checks++; if (debug_state !== 3'(frame.size())) begin failures++; $display("FAIL held_valid_state got=%0d exp=%0d", debug_state, frame.size()); end
    send_error(1'b0, 8'h00, 2);
    settle(1);
    checks++; if (mon_tmo !== e_tmo || debug_state !== 3'(frame.size())) begin failures++; $display("FAIL err_abort got=%0d/%0d exp=%0d/%0d", mon_tmo, debug_state, e_tmo, frame.size()); end
    send_error(1'b0, 8'h00, 2);   // idle: ignored
    settle(1);
    checks++; if (mon_tmo !== e_tmo) begin failures++; $display("FAIL err_idle got=%0d exp=%0d", mon_tmo, e_tmo); end
    send_byte(8'hA5, 1, 1); send_byte(8'h02, 1, 1); send_byte(8'h00, 1, 1); send_byte(8'h10, 1, 1);
    send_error(1'b1, 8'h12, 2);   // error and checksum byte together: error wins
    settle(2);
    checks++; if (mon_tmo !== e_tmo || ilim !== m_ilim || debug_state !== 3'(frame.size())) begin failures++; $display("FAIL err_beats_byte got=%0d/%h/%0d exp=%0d/%h/%0d", mon_tmo, ilim, debug_state, e_tmo, m_ilim, frame.size()); end
  endtask

  task automatic test_reset_midframe();
    int tmo_before;
    send_frame(8'hA5, 8'h03, 8'h00, 8'h05, 8'h08, 1, 1);
    send_byte(8'hA5, 1, 1); send_byte(8'h01, 1, 1); send_byte(8'h33, 1, 1);
    rst_n = 1'b0;
    model_reset();
    tmo_before = e_tmo;
    @(negedge clk_27m);
    checks++; if (vset !== m_vset || ilim !== m_ilim || pwr_en !== m_en || mode !== m_mode) begin failures++; $display("FAIL midrst_regs got=%h/%h/%b/%b exp=%h/%h/%b/%b", vset, ilim, pwr_en, mode, m_vset, m_ilim, m_en, m_mode); end
    checks++; if (cmd_id !== m_id || frame_cnt !== m_cnt || debug_state !== 3'd0) begin failures++; $display("FAIL midrst_cnt got=%h/%h/%0d exp=%h/%h/0", cmd_id, frame_cnt, debug_state, m_id, m_cnt); end
    rst_n = 1'b1;
    settle(T_CYC + 3);
    checks++; if (mon_tmo !== tmo_before) begin failures++; $display("FAIL midrst_silent got=%0d exp=%0d", mon_tmo, tmo_before); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h79, 1, 1);
    send_frame(8'hA5, 8'h02, 8'h12, 8'h34, 8'h48, 1, 1);
    send_frame(8'hA5, 8'h03, 8'h00, 8'h07, 8'h0A, 1, 1);
    send_frame(8'hA5, 8'h04, 8'hFF, 8'hFF, 8'h02, 1, 1);
    settle(2);
    checks++; if (vset !== m_vset || ilim !== m_ilim || pwr_en !== m_en || mode !== m_mode) begin failures++; $display("FAIL b2b_regs got=%h/%h/%b/%b exp=%h/%h/%b/%b", vset, ilim, pwr_en, mode, m_vset, m_ilim, m_en, m_mode); end
    checks++; if (frame_cnt !== m_cnt || mon_valid !== e_valid) begin failures++; $display("FAIL b2b_count got=%h/%0d exp=%h/%0d", frame_cnt, mon_valid, m_cnt, e_valid); end
  endtask

  task automatic test_random();
    logic [7:0] b[5];
    logic [7:0] cmd, dh, dl;
    int r;
    for (int f = 0; f < 40; f++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++)
        send_byte(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(1, 10)));
      r = int'($urandom_range(0, 9));
      cmd = (r < 8) ? 8'(r % 4 + 1) : 8'($urandom);
      dh = 8'($urandom); dl = 8'($urandom);
      b[0] = 8'hA5; b[1] = cmd; b[2] = dh; b[3] = dl;
      b[4] = 8'((int'(cmd) + int'(dh) + int'(dl)) % 256);
      if ($urandom_range(0, 4) == 0) b[4] = b[4] ^ 8'($urandom_range(1, 255));
      for (int k = 0; k < 5; k++)
        send_byte(b[k], int'($urandom_range(1, 3)),
                  ($urandom_range(0, 15) == 0) ? T_CYC + int'($urandom_range(0, 20)) : int'($urandom_range(1, 40)));
      settle(2);
      checks++; if (vset !== m_vset || ilim !== m_ilim || pwr_en !== m_en || mode !== m_mode) begin failures++; $display("FAIL rand_regs f=%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", f, vset, ilim, pwr_en, mode, m_vset, m_ilim, m_en, m_mode); end
      checks++; if (cmd_id !== m_id || frame_cnt !== m_cnt) begin failures++; $display("FAIL rand_id_cnt f=%0d got=%h/%h exp=%h/%h", f, cmd_id, frame_cnt, m_id, m_cnt); end
      checks++; if (mon_valid !== e_valid || mon_chk !== e_chk || mon_cmd !== e_cmd || mon_tmo !== e_tmo) begin failures++; $display("FAIL rand_pulses f=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", f, mon_valid, mon_chk, mon_cmd, mon_tmo, e_valid, e_chk, e_cmd, e_tmo); end
      if (frame.size() == 0 || cyc + 2 < last_strobe + T_CYC) begin
        checks++; if (debug_state !== 3'(frame.size())) begin failures++; $display("FAIL rand_state f=%0d got=%0d exp=%0d", f, debug_state, frame.size()); end
      end
    end
  endtask

  task automatic test_exclusive_pulses();
    checks++; if (mon_multi !== 0) begin failures++; $display("FAIL exclusive_pulses got=%0d exp=0", mon_multi); end
  endtask

  initial begin
    test_reset();
    test_vset_frame();
    test_ctrl_off();
    test_bad_checksum();
    test_timeout();
    test_garbage_unknown();
    test_error_abort();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    settle(T_CYC + 3);
    test_exclusive_pulses();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
